// File: rtl/lif_neuron_array.sv
// rtl/lif_neuron_array.sv - time-multiplexed leaky integrate-and-fire neuron array
//
// Purpose:
//   N_CH leaky integrate-and-fire neurons share one update datapath. Each accepted
//   step_i advances every channel by one time step, one channel per clock:
//   leak, integrate, saturate, threshold, spike, refractory.
//
// Optional feature macro: LIF_SPIKE_COUNT_EN
//   defined   -> per-channel 8-bit saturating spike counters, visible on cnt_o
//   undefined -> no counters, cnt_o tied to zero
//
// Ports:
//   clk        in   clock, all state on rising edge
//   rst        in   synchronous reset, active-high
//   step_i     in   start one time step (accepted only while ready_o=1)
//   current_i  in   channel k current at [k*I_W +: I_W]
//   ready_o    out  1 = idle, step_i will be accepted
//   done_o     out  one-cycle pulse: step complete, spike_o updated
//   spike_o    out  spike flags of the last completed step
//   v_sel_i    in   channel select for v_o/cnt_o
//   v_o        out  stored membrane voltage of the selected channel
//   cnt_o      out  spike count of the selected channel

module lif_neuron_array #(
  parameter int N_CH       = 4,
  parameter int V_W        = 14,
  parameter int I_W        = 8,
  parameter int LEAK_SHIFT = 3,
  parameter int THRESH     = 12000,
  parameter int REFRACT    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    step_i,
  input  logic [N_CH*I_W-1:0]     current_i,
  output logic                    ready_o,
  output logic                    done_o,
  output logic [N_CH-1:0]         spike_o,
  input  logic [$clog2(N_CH)-1:0] v_sel_i,
  output logic [V_W-1:0]          v_o,
  output logic [7:0]              cnt_o
);

  localparam int CH_W = $clog2(N_CH);
  // Refractory counter must hold REFRACT; keep at least one bit when REFRACT=0.
  localparam int R_W = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  localparam logic [R_W-1:0]  REFR_INIT = R_W'(REFRACT);
  localparam logic [V_W:0]    THRESH_X  = (V_W + 1)'(THRESH);
  localparam logic [CH_W-1:0] LAST_CH   = CH_W'(N_CH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_UPDATE,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [CH_W-1:0]     r_ch;
  logic [N_CH*I_W-1:0] r_cur;
  logic [V_W-1:0]      r_v    [N_CH];
  logic [R_W-1:0]      r_refr [N_CH];
  logic [N_CH-1:0]     r_shadow;
  logic [N_CH-1:0]     r_spike;
  logic                r_ready;
  logic                r_done;
`ifdef LIF_SPIKE_COUNT_EN
  logic [7:0]          r_cnt  [N_CH];
`endif

  // Shared datapath for the channel currently addressed by r_ch.
  logic [I_W-1:0]  w_i;
  logic [V_W-1:0]  w_v;
  logic [V_W-1:0]  w_leak;
  logic [V_W:0]    w_i_ext;
  logic [V_W:0]    w_sum;
  logic [V_W-1:0]  w_vsat;
  logic            w_busy;
  logic            w_fire;
  logic            w_spk_bit;
  logic [N_CH-1:0] w_shadow_next;
  logic [CH_W:0]   w_sel_ext;

  assign w_i     = r_cur[r_ch*I_W +: I_W];
  assign w_v     = r_v[r_ch];
  assign w_leak  = w_v >> LEAK_SHIFT;
  assign w_i_ext = {{(V_W + 1 - I_W){1'b0}}, w_i} << (V_W - I_W);
  // One extra bit of headroom: leak never exceeds v, so only the add can carry out.
  assign w_sum   = {1'b0, w_v} - {1'b0, w_leak} + w_i_ext;
  assign w_vsat  = w_sum[V_W] ? {V_W{1'b1}} : w_sum[V_W-1:0];
  assign w_busy  = (r_refr[r_ch] != '0);
  assign w_fire  = ({1'b0, w_vsat} >= THRESH_X);
  assign w_spk_bit = !w_busy && w_fire;

  // Spike flags including the channel being written this cycle, so the last
  // channel's bit reaches spike_o together with done_o.
  always_comb begin
    w_shadow_next = r_shadow;
    w_shadow_next[r_ch] = w_spk_bit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ch     <= '0;
      r_cur    <= '0;
      r_shadow <= '0;
      r_spike  <= '0;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        r_v[k]    <= '0;
        r_refr[k] <= '0;
`ifdef LIF_SPIKE_COUNT_EN
        r_cnt[k]  <= '0;
`endif
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (step_i) begin
            r_cur   <= current_i;
            r_ch    <= '0;
            r_ready <= 1'b0;
            r_state <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          if (w_busy) begin
            r_v[r_ch]    <= '0;
            r_refr[r_ch] <= r_refr[r_ch] - 1'b1;
          end else if (w_fire) begin
            r_v[r_ch]    <= '0;
            r_refr[r_ch] <= REFR_INIT;
          end else begin
            r_v[r_ch]    <= w_vsat;
          end
`ifdef LIF_SPIKE_COUNT_EN
          if (w_spk_bit && (r_cnt[r_ch] != 8'hFF)) begin
            r_cnt[r_ch] <= r_cnt[r_ch] + 8'd1;
          end
`endif
          r_shadow <= w_shadow_next;
          if (r_ch == LAST_CH) begin
            r_spike <= w_shadow_next;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_ch <= r_ch + 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready_o = r_ready;
  assign done_o  = r_done;
  assign spike_o = r_spike;

  // Out-of-range selects read as zero; the extra bit keeps the compare meaningful
  // when N_CH is a power of two.
  assign w_sel_ext = {1'b0, v_sel_i};

  always_comb begin
    v_o   = '0;
    cnt_o = 8'd0;
    if (w_sel_ext < (CH_W + 1)'(N_CH)) begin
      v_o = r_v[v_sel_i];
`ifdef LIF_SPIKE_COUNT_EN
      cnt_o = r_cnt[v_sel_i];
`endif
    end
  end

endmodule
